util_sync_fifo: RTL and testbench

//   Parametrised single-clock FIFO with occupancy count, programmable almost-full/almost-empty flags and

---
 rtl/util_sync_fifo.sv | 124 ++++++++++++
 tb/tb_util_sync_fifo.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/util_sync_fifo.sv
// util_sync_fifo: single-clock FIFO with occupancy count, almost-full/almost-empty flags and error pulses.
// Optional macro UTIL_SYNC_FIFO_FWFT_EN selects first-word fall-through output instead of a registered read port.
module util_sync_fifo #(
  parameter int DATA_W    = 64,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = 6,
  parameter int AE_THRESH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        din,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        dout,
  output logic                     dout_valid,
  output logic                     full,
  output logic                     almost_full,
  output logic                     empty,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  localparam logic [CNT_W-1:0]  FULL_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  AF_C   = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0]  AE_C   = CNT_W'(AE_THRESH);
  localparam logic [CNT_W-1:0]  CONE_C = CNT_W'(1);
  localparam logic [ADDR_W-1:0] PONE_C = ADDR_W'(1);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic [CNT_W-1:0]  count_nxt_s;
  logic              overflow_r;
  logic              underflow_r;
  logic              wr_ok_s;
  logic              rd_ok_s;
  logic              full_s;
  logic              empty_s;

  // Status flags decode the registered occupancy only, so they never glitch with the request inputs.
  assign full_s       = (count_r == FULL_C);
  assign empty_s      = (count_r == {CNT_W{1'b0}});
  assign full         = full_s;
  assign empty        = empty_s;
  assign almost_full  = (count_r >= AF_C);
  assign almost_empty = (count_r <= AE_C);
  assign count        = count_r;
  assign overflow     = overflow_r;
  assign underflow    = underflow_r;

  // Request acceptance and next occupancy.
  always_comb begin
    wr_ok_s     = 1'b0;
    rd_ok_s     = 1'b0;
    count_nxt_s = count_r;
    wr_ok_s     = wr_en && !full_s;
    rd_ok_s     = rd_en && !empty_s;
    case ({wr_ok_s, rd_ok_s})
      2'b10:   count_nxt_s = count_r + CONE_C;
      2'b01:   count_nxt_s = count_r - CONE_C;
      default: count_nxt_s = count_r;
    endcase
  end

  // Storage array; deliberately not reset, the cleared pointers hide stale words.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers, occupancy and error pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r    <= {ADDR_W{1'b0}};
      rd_ptr_r    <= {ADDR_W{1'b0}};
      count_r     <= {CNT_W{1'b0}};
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (wr_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PONE_C;
      end
      if (rd_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PONE_C;
      end
      count_r     <= count_nxt_s;
      overflow_r  <= wr_en && full_s;
      underflow_r <= rd_en && empty_s;
    end
  end

`ifdef UTIL_SYNC_FIFO_FWFT_EN
  // Head word is presented directly; rd_en pops it.
  assign dout       = mem_r[rd_ptr_r];
  assign dout_valid = !empty_s;
`else
  logic [DATA_W-1:0] dout_r;
  logic              dout_valid_r;

  // Registered read port: one cycle latency, dout holds the last word read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout_r       <= {DATA_W{1'b0}};
      dout_valid_r <= 1'b0;
    end else begin
      if (rd_ok_s) begin
        dout_r <= mem_r[rd_ptr_r];
      end
      dout_valid_r <= rd_ok_s;
    end
  end

  assign dout       = dout_r;
  assign dout_valid = dout_valid_r;
`endif

endmodule

// File: tb/tb_util_sync_fifo.sv
// Self-checking bench for util_sync_fifo (DEPTH=8, AF=6, AE=2); table-driven fill/drain plus corner sequences.
// Read data is checked through a scoreboard queue; build with UTIL_SYNC_FIFO_FWFT_EN to check the FWFT variant.
module tb_util_sync_fifo;

  localparam int DATA_W = 64;
  localparam int DEPTH  = 8;

  logic              clk;
  logic              rst_n;
  logic              wr_en;
  logic [DATA_W-1:0] din;
  logic              rd_en;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              full;
  logic              almost_full;
  logic              empty;
  logic              almost_empty;
  logic [3:0]        count;
  logic              overflow;
  logic              underflow;

  int n_checks   = 0;
  int n_failures = 0;
  int exp_prev   = 0;
  logic [DATA_W-1:0] sb_q [$];

  typedef struct {
    logic              wr;
    logic              rd;
    logic [DATA_W-1:0] d;
    int                ec;
    logic              eo;
    logic              eu;
  } vec_t;

  vec_t vecs [20];

  util_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_THRESH(6), .AE_THRESH(2)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(dout), .dout_valid(dout_valid), .full(full), .almost_full(almost_full),
    .empty(empty), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic chk_status(input int ec, input logic eo, input logic eu);
    chk("count", 64'(count), 64'(ec));
    chk("empty", 64'(empty), 64'(ec == 0));
    chk("full", 64'(full), 64'(ec == DEPTH));
    chk("almost_full", 64'(almost_full), 64'(ec >= 6));
    chk("almost_empty", 64'(almost_empty), 64'(ec <= 2));
    chk("overflow", 64'(overflow), 64'(eo));
    chk("underflow", 64'(underflow), 64'(eu));
  endtask

  // One clock of stimulus; ec/eo/eu are the expected status after the edge.
  task automatic step(input logic wr, input logic rd, input logic [DATA_W-1:0] d,
                      input int ec, input logic eo, input logic eu);
    logic wa;
    logic ra;
    logic [DATA_W-1:0] exp_d;
    exp_d = '0;
    @(negedge clk);
    wr_en = wr;
    rd_en = rd;
    din   = d;
    wa = wr && (exp_prev != DEPTH);
    ra = rd && (exp_prev != 0);
    if (ra) begin
      if (sb_q.size() == 0) begin
        chk("scoreboard_nonempty", 64'(0), 64'(1));
        ra = 1'b0;
      end else begin
        exp_d = sb_q.pop_front();
      end
    end
    if (wa) begin
      sb_q.push_back(d);
    end
`ifdef UTIL_SYNC_FIFO_FWFT_EN
    #1;
    chk("fwft_valid_pre", 64'(dout_valid), 64'(exp_prev != 0));
    if (ra) begin
      chk("fwft_dout", dout, exp_d);
    end
`endif
    @(posedge clk);
    #1;
    chk_status(ec, eo, eu);
`ifdef UTIL_SYNC_FIFO_FWFT_EN
    chk("fwft_valid_post", 64'(dout_valid), 64'(ec != 0));
`else
    chk("dout_valid", 64'(dout_valid), 64'(ra));
    if (ra) begin
      chk("dout", dout, exp_d);
    end
`endif
    exp_prev = ec;
  endtask

  // Hold reset for two edges with both requests asserted, then release.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    wr_en = 1'b1;
    rd_en = 1'b1;
    din   = 64'hDEAD_BEEF_0000_0001;
    repeat (2) begin
      @(posedge clk);
      #1;
      chk_status(0, 1'b0, 1'b0);
      chk("reset_dout_valid", 64'(dout_valid), 64'(0));
`ifndef UTIL_SYNC_FIFO_FWFT_EN
      chk("reset_dout", dout, 64'h0);
`endif
    end
    @(negedge clk);
    rst_n = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    sb_q.delete();
    exp_prev = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    wr_en = 1'b1;
    rd_en = 1'b1;
    din   = '0;

    // T2 fill/drain table: 8 writes, overflow on a ninth, 8 reads, underflow on a ninth.
    for (int i = 0; i < 8; i++) begin
      vecs[i] = '{1'b1, 1'b0, 64'(16 + i), i + 1, 1'b0, 1'b0};
    end
    vecs[8] = '{1'b1, 1'b0, 64'h18, 8, 1'b1, 1'b0};
    vecs[9] = '{1'b0, 1'b0, 64'h0, 8, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      vecs[10 + i] = '{1'b0, 1'b1, 64'h0, 7 - i, 1'b0, 1'b0};
    end
    vecs[18] = '{1'b0, 1'b1, 64'h0, 0, 1'b0, 1'b1};
    vecs[19] = '{1'b0, 1'b0, 64'h0, 0, 1'b0, 1'b0};

    // T1 reset with both requests held high
    do_reset();

    for (int i = 0; i < 20; i++) begin
      step(vecs[i].wr, vecs[i].rd, vecs[i].d, vecs[i].ec, vecs[i].eo, vecs[i].eu);
    end

    // T3 pointer wrap
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 64'(32 + i), i + 1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 64'h0, 4 - i, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 64'(160 + i), i + 1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 64'h0, 7 - i, 1'b0, 1'b0);

    // T4 simultaneous requests at mid, full and empty occupancy
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 64'(176 + i), i + 1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 64'(192 + i), 3, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 64'(208 + i), 4 + i, 1'b0, 1'b0);
    step(1'b1, 1'b1, 64'hEE, 7, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 64'h0, 6 - i, 1'b0, 1'b0);
    step(1'b1, 1'b1, 64'h77, 1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 64'h0, 0, 1'b0, 1'b0);

    // T5 reset mid-operation discards contents
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 64'(224 + i), i + 1, 1'b0, 1'b0);
    do_reset();
    step(1'b0, 1'b1, 64'h0, 0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 64'h99, 1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 64'h0, 0, 1'b0, 1'b0);

`ifdef UTIL_SYNC_FIFO_FWFT_EN
    // T6 fall-through: word visible before any read request
    step(1'b1, 1'b0, 64'h55, 1, 1'b0, 1'b0);
    chk("fwft_head", dout, 64'h55);
    step(1'b0, 1'b1, 64'h0, 0, 1'b0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
    $finish;
  end

endmodule
